// File: rtl/bus_dest_decoder.sv
// bus_dest_decoder
//   Write-side counterpart of the bus source encoder. Takes a destination
//   select code over a valid/ready handshake and drives exactly one one-hot
//   register write enable for HOLD_CYCLES cycles, then pulses done.
//   Out-of-range codes are absorbed without driving anything and are
//   reported through a sticky error flag plus the first offending code.
//
// Ports
//   clock      in   rising-edge clock
//   clear      in   synchronous reset, active low
//   sel_valid  in   select code presented
//   sel_code   in   destination code (0-15 r0-r15, 16 HI, 17 LO, 18 Z_HI,
//                   19 Z_LO, 20 PC, 21 MDR, 22 InPort, 23 Cout)
//   sel_ready  out  decoder can accept a code
//   dest_en    out  one-hot write enable, bit k = code k
//   busy       out  decoder is driving or completing a transfer
//   done       out  one-cycle pulse after the enable deasserts
//   err_flag   out  sticky: an out-of-range code was accepted
//   err_code   out  first out-of-range code accepted since reset
//
// All outputs are registered from the FSM state, so they trail the state
// by one cycle.

module bus_dest_decoder #(
    parameter int NUM_DEST    = 24,
    parameter int SEL_W       = 5,
    parameter int HOLD_CYCLES = 1
) (
    input  logic                clock,
    input  logic                clear,
    input  logic                sel_valid,
    input  logic [SEL_W-1:0]    sel_code,
    output logic                sel_ready,
    output logic [NUM_DEST-1:0] dest_en,
    output logic                busy,
    output logic                done,
    output logic                err_flag,
    output logic [SEL_W-1:0]    err_code
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } stateT;

    stateT               state;
    stateT               nextState;
    logic [3:0]          holdCnt;
    logic [SEL_W-1:0]    latchedCode;
    logic                accept;
    logic                codeLegal;
    logic                takeLegal;
    logic                readyNext;
    logic [NUM_DEST-1:0] destEnNext;

    assign accept    = sel_valid & sel_ready;
    assign codeLegal = (32'(sel_code) < 32'(NUM_DEST));
    assign takeLegal = accept & codeLegal;

    // sel_ready is only ever high in IDLE, so an accept always happens there.
    // Ready drops the same edge a legal code is taken; illegal codes leave
    // it up so one can be absorbed every cycle.
    assign readyNext = (state == IDLE) && !takeLegal;

    // One comparator per destination keeps the enable one-hot by construction.
    for (genvar k = 0; k < NUM_DEST; k++) begin : gDest
        assign destEnNext[k] = (state == DRIVE) && (latchedCode == SEL_W'(k));
    end

    // State register
    always_ff @(posedge clock) begin
        if (!clear) state <= IDLE;
        else        state <= nextState;
    end

    // Next-state logic
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (takeLegal) nextState = DRIVE;
            DRIVE:   if (holdCnt == 4'd0) nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clock) begin
        if (!clear) begin
            holdCnt     <= 4'd0;
            latchedCode <= '0;
            dest_en     <= '0;
            done        <= 1'b0;
            busy        <= 1'b0;
            sel_ready   <= 1'b0;
            err_flag    <= 1'b0;
            err_code    <= '0;
        end else begin
            if (takeLegal) begin
                latchedCode <= sel_code;
                holdCnt     <= 4'(HOLD_CYCLES - 1);
            end else if (state == DRIVE && holdCnt != 4'd0) begin
                holdCnt <= holdCnt - 4'd1;
            end

            dest_en   <= destEnNext;
            done      <= (state == DONE);
            busy      <= (state != IDLE);
            sel_ready <= readyNext;

            // First error wins: the code is captured only while the flag is clear.
            if (accept && !codeLegal) begin
                err_flag <= 1'b1;
                if (!err_flag) err_code <= sel_code;
            end
        end
    end

endmodule
